// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared constants and types for the register-file writeback
//               arbiter: register addressing, x0 and the writeback entry.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DEFAULT_XLEN = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  // Writeback entry layout {dest, data} at the default data width; the FIFO
  // stores the same layout packed as a flat vector so XLEN stays a parameter.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   dest;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_entry_t;

  // Writes targeting x0 complete their handshake but never reach the file.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
    return (r == X0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO buffering load writebacks. Power-of-two
//               depth so the pointers wrap naturally. Push while full and
//               pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Occupancy next-state: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until validated by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file write port between the unbuffered
//               ALU writeback and the FIFO-buffered load writeback, with a
//               starvation limit on the ALU and a per-register load
//               scoreboard for decode RAW stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  input  logic                  mark_valid,
  input  logic [REG_ADDR_W-1:0] mark_dest,
  input  logic [REG_ADDR_W-1:0] chk_src_one,
  input  logic [REG_ADDR_W-1:0] chk_src_two,
  output logic                  hazard_one,
  output logic                  hazard_two,
  output logic [REG_ADDR_W-1:0] rf_dest,
  output logic                  rf_write_enable,
  output logic [XLEN-1:0]       rf_data_in
);

  localparam int ENTRY_W  = REG_ADDR_W + XLEN;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [ENTRY_W-1:0]    w_head;
  logic [REG_ADDR_W-1:0] w_head_dest;
  logic [XLEN-1:0]       w_head_data;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_nonempty;
  logic                  w_push;
  logic                  w_starved;
  logic                  w_grant_mem;
  logic                  w_grant_alu;

  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [REG_ADDR_W-1:0] rf_dest_q, rf_dest_d;
  logic                  rf_we_q, rf_we_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  // No pop-through: a full FIFO refuses a push even while it is popping.
  assign mem_ready = (w_fifo_count < CNT_W'(FIFO_DEPTH));
  assign w_push    = mem_valid && mem_ready;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i ({mem_dest, mem_data}),
    .pop_i       (w_grant_mem),
    .head_o      (w_head),
    .count_o     (w_fifo_count),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  assign w_head_dest = w_head[ENTRY_W-1:XLEN];
  assign w_head_data = w_head[XLEN-1:0];
  assign w_nonempty  = !w_fifo_empty;

  // The memory path is forced through when the ALU has used up its allowance
  // or the buffer is full; alu_ready is deliberately independent of alu_valid.
  assign w_starved   = w_nonempty && ((starve_cnt_q == STARVE_W'(STARVE_MAX)) || w_fifo_full);
  assign w_grant_mem = w_nonempty && (!alu_valid || w_starved);
  assign w_grant_alu = alu_valid && !w_grant_mem;
  assign alu_ready   = !w_starved;

  // Starvation counter: counts ALU wins while a load is waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (w_grant_mem || !w_nonempty) begin
      starve_cnt_d = '0;
    end else if (w_grant_alu && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  // Scoreboard: new loads set, retiring loads clear; a set wins a same-cycle clear.
  always_comb begin
    busy_d = busy_q;
    if (w_grant_mem) busy_d[w_head_dest] = 1'b0;
    if (mark_valid && !is_x0(mark_dest)) busy_d[mark_dest] = 1'b1;
    busy_d[X0] = 1'b0;
  end

  assign hazard_one = busy_q[chk_src_one];
  assign hazard_two = busy_q[chk_src_two];

  // Output register next-state: latch the winner, suppress the enable for x0.
  always_comb begin
    rf_dest_d = rf_dest_q;
    rf_data_d = rf_data_q;
    rf_we_d   = 1'b0;
    if (w_grant_mem) begin
      rf_dest_d = w_head_dest;
      rf_data_d = w_head_data;
      rf_we_d   = !is_x0(w_head_dest);
    end else if (w_grant_alu) begin
      rf_dest_d = alu_dest;
      rf_data_d = alu_data;
      rf_we_d   = !is_x0(alu_dest);
    end
  end

  // State registers for the counter, scoreboard and register-file outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      busy_q       <= '0;
      rf_dest_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      rf_dest_q    <= rf_dest_d;
      rf_we_q      <= rf_we_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign rf_dest         = rf_dest_q;
  assign rf_write_enable = rf_we_q;
  assign rf_data_in      = rf_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter. Expected
//               register-file writes are queued when the winning request is
//               driven and compared in order when the write appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        mark_valid;
  logic [4:0]  mark_dest;
  logic [4:0]  chk_src_one;
  logic [4:0]  chk_src_two;
  logic        hazard_one;
  logic        hazard_two;
  logic [4:0]  rf_dest;
  logic        rf_write_enable;
  logic [31:0] rf_data_in;

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  regfile_wb_arbiter #(
    .XLEN       (32),
    .FIFO_DEPTH (2),
    .STARVE_MAX (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_dest        (alu_dest),
    .alu_data        (alu_data),
    .alu_ready       (alu_ready),
    .mem_valid       (mem_valid),
    .mem_dest        (mem_dest),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .mark_valid      (mark_valid),
    .mark_dest       (mark_dest),
    .chk_src_one     (chk_src_one),
    .chk_src_two     (chk_src_two),
    .hazard_one      (hazard_one),
    .hazard_two      (hazard_two),
    .rf_dest         (rf_dest),
    .rf_write_enable (rf_write_enable),
    .rf_data_in      (rf_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic expect_wr(input logic [4:0] d, input logic [31:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then compare any register-file write against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (rf_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, rf_write_enable}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_dest", {59'd0, rf_dest}, {59'd0, e.d});
        chk("wb_data", {32'd0, rf_data_in}, {32'd0, e.v});
      end
    end
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    mem_valid  = 1'b0;
    mark_valid = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    mark_valid = 1'b0; mark_dest = '0;
    chk_src_one = '0; chk_src_two = '0;

    // Reset state
    tick();
    tick();
    chk("rst_we",        {63'd0, rf_write_enable}, 64'd0);
    chk("rst_dest",      {59'd0, rf_dest}, 64'd0);
    chk("rst_data",      {32'd0, rf_data_in}, 64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
    reset = 1'b0;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hA5A5_A5A5;
    #1 chk("alu_ready_idle", {63'd0, alu_ready}, 64'd1);
    expect_wr(5'd5, 32'hA5A5_A5A5);
    tick();
    chk("alu_we", {63'd0, rf_write_enable}, 64'd1);
    idle_inputs();

    // Load through the FIFO with scoreboard
    mark_valid = 1'b1; mark_dest = 5'd7; chk_src_one = 5'd7;
    #1 chk("ld_hazard_before_mark", {63'd0, hazard_one}, 64'd0);
    tick();
    mark_valid = 1'b0;
    mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h0000_1234;
    #1 chk("ld_hazard_set", {63'd0, hazard_one}, 64'd1);
    chk("ld_mem_ready", {63'd0, mem_ready}, 64'd1);
    expect_wr(5'd7, 32'h0000_1234);
    tick();
    mem_valid = 1'b0;
    #1 chk("ld_no_write_yet", {63'd0, rf_write_enable}, 64'd0);
    chk("ld_hazard_pending", {63'd0, hazard_one}, 64'd1);
    tick();
    chk("ld_write_lat2", {63'd0, rf_write_enable}, 64'd1);
    chk("ld_hazard_clear", {63'd0, hazard_one}, 64'd0);

    // Starvation: one load waiting, ALU requesting every cycle
    mem_valid = 1'b1; mem_dest = 5'd10; mem_data = 32'h0000_BEEF;
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd11;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'h100 + i;
      #1 chk($sformatf("starve_alu_win%0d", i), {63'd0, alu_ready}, 64'd1);
      expect_wr(5'd11, 32'h100 + i);
      tick();
    end
    alu_data = 32'h103;
    #1 chk("starve_alu_blocked", {63'd0, alu_ready}, 64'd0);
    expect_wr(5'd10, 32'h0000_BEEF);
    tick();
    #1 chk("starve_alu_resume", {63'd0, alu_ready}, 64'd1);
    expect_wr(5'd11, 32'h103);
    tick();

    // FIFO full while the ALU keeps winning
    alu_dest = 5'd12; alu_data = 32'h200;
    mem_valid = 1'b1; mem_dest = 5'd13; mem_data = 32'h300;
    #1 chk("full_ready0", {63'd0, mem_ready}, 64'd1);
    expect_wr(5'd12, 32'h200);
    tick();
    alu_data = 32'h201; mem_dest = 5'd14; mem_data = 32'h301;
    #1 chk("full_ready1", {63'd0, mem_ready}, 64'd1);
    expect_wr(5'd12, 32'h201);
    tick();
    mem_valid = 1'b0; alu_data = 32'h202;
    #1 chk("full_mem_ready", {63'd0, mem_ready}, 64'd0);
    chk("full_alu_ready", {63'd0, alu_ready}, 64'd0);
    expect_wr(5'd13, 32'h300);
    tick();
    #1 chk("full_mem_ready_back", {63'd0, mem_ready}, 64'd1);
    chk("full_alu_after", {63'd0, alu_ready}, 64'd1);
    expect_wr(5'd12, 32'h202);
    tick();
    alu_valid = 1'b0;
    expect_wr(5'd14, 32'h301);
    tick();
    tick();

    // Load to x0: consumed but not written
    mem_valid = 1'b1; mem_dest = 5'd0; mem_data = 32'hDEAD_0000;
    tick();
    mem_valid = 1'b0;
    tick();
    tick();
    chk("x0_we", {63'd0, rf_write_enable}, 64'd0);
    chk("x0_dest", {59'd0, rf_dest}, 64'd0);
    chk("x0_data", {32'd0, rf_data_in}, {32'd0, 32'hDEAD_0000});

    // Same-cycle set and clear of busy[9]
    mark_valid = 1'b1; mark_dest = 5'd9; chk_src_two = 5'd9;
    tick();
    mark_valid = 1'b0;
    mem_valid = 1'b1; mem_dest = 5'd9; mem_data = 32'h999;
    #1 chk("sc_hazard_set", {63'd0, hazard_two}, 64'd1);
    tick();
    mem_valid = 1'b0;
    mark_valid = 1'b1; mark_dest = 5'd9;
    expect_wr(5'd9, 32'h999);
    tick();
    mark_valid = 1'b0;
    chk("sc_write", {63'd0, rf_write_enable}, 64'd1);
    chk("sc_set_wins", {63'd0, hazard_two}, 64'd1);

    // Mid-operation reset with two buffered loads and busy[3]
    mark_valid = 1'b1; mark_dest = 5'd3; chk_src_one = 5'd3;
    mem_valid = 1'b1; mem_dest = 5'd20; mem_data = 32'h1;
    tick();
    mark_valid = 1'b0;
    mem_dest = 5'd21; mem_data = 32'h2;
    alu_valid = 1'b1; alu_dest = 5'd22; alu_data = 32'h55;
    expect_wr(5'd22, 32'h55);
    tick();
    idle_inputs();
    #1 chk("rst2_full", {63'd0, mem_ready}, 64'd0);
    chk("rst2_hazard_pre", {63'd0, hazard_one}, 64'd1);
    reset = 1'b1;
    tick();
    chk("rst2_we", {63'd0, rf_write_enable}, 64'd0);
    chk("rst2_hazard", {63'd0, hazard_one}, 64'd0);
    chk("rst2_mem_ready", {63'd0, mem_ready}, 64'd1);
    reset = 1'b0;
    tick();
    chk("rst2_no_stale_write", {63'd0, rf_write_enable}, 64'd0);
    tick();
    chk("rst2_no_stale_write2", {63'd0, rf_write_enable}, 64'd0);

    chk("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
